// File: rtl/task_answer_packetizer.sv
// Packs answer words plus size/latency metadata into a byte stream for a UART transmitter.
// Build option: define TASK_ANSWER_PACKETIZER_CRC_EN to append a CRC-8 trailer byte.
module task_answer_packetizer #(
  parameter int unsigned FIFO_DEPTH = 256,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_answer_valid,
  input  logic [31:0] i_answer_data,
  input  logic        i_answer_last,
  input  logic [31:0] i_answer_size_in_bytes,
  input  logic [31:0] i_answer_latency,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_tx_last,
  output logic        o_busy,
  output logic        o_overflow
);
  // state   | meaning
  // IDLE    | waiting for a pending metadata entry
  // SYNC    | presenting SYNC_BYTE
  // SIZE    | presenting payload size, LSB first
  // LAT     | presenting task latency, LSB first
  // PAYLOAD | presenting payload bytes from the word FIFO
  // CRC     | presenting the CRC-8 trailer (CRC build only)

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

`ifdef TASK_ANSWER_PACKETIZER_CRC_EN
  localparam logic HAS_CRC = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_SIZE, S_LAT, S_PAYLOAD, S_CRC} state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction
`else
  localparam logic HAS_CRC = 1'b0;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_SIZE, S_LAT, S_PAYLOAD} state_t;
`endif

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_cnt;
  logic        fifo_empty, fifo_full, fifo_multi, fifo_wr, fifo_pop;
  logic [31:0] head_word, next_word;

  logic        meta_full_q, meta_full_d, meta_load, release_meta;
  logic [31:0] meta_size_q, meta_size_d, meta_lat_q, meta_lat_d;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] rem_q, rem_d, size_w_q, size_w_d, lat_w_q, lat_w_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic        busy_q, busy_d, overflow_q, overflow_d;
  logic        xfer, body_done;
`ifdef TASK_ANSWER_PACKETIZER_CRC_EN
  logic [7:0]  crc_q, crc_d;
`endif

  // Count is wr-rd on AW+1 bit pointers, so bit AW alone flags a full FIFO.
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = fifo_cnt[AW];
  assign fifo_multi = (fifo_cnt > (AW+1)'(1));
  assign fifo_wr    = i_answer_valid & ~fifo_full;
  assign head_word  = mem_q[rd_ptr_q[AW-1:0]];
  assign next_word  = mem_q[rd_ptr_q[AW-1:0] + AW'(1)];
  assign wr_ptr_d   = wr_ptr_q + (AW+1)'(fifo_wr);
  assign rd_ptr_d   = rd_ptr_q + (AW+1)'(fifo_pop);

  always_ff @(posedge i_clk) begin
    if (fifo_wr) mem_q[wr_ptr_q[AW-1:0]] <= i_answer_data;
  end

  assign meta_load = i_answer_valid & i_answer_last;
  assign xfer      = tx_valid_q & i_tx_ready;

  always_comb begin
    meta_full_d = meta_full_q;
    meta_size_d = meta_size_q;
    meta_lat_d  = meta_lat_q;
    if (release_meta) meta_full_d = 1'b0;
    if (meta_load && (!meta_full_q || release_meta)) begin
      meta_full_d = 1'b1;
      meta_size_d = i_answer_size_in_bytes;
      meta_lat_d  = i_answer_latency;
    end
    overflow_d = overflow_q | (i_answer_valid & fifo_full) |
                 (meta_load & meta_full_q & ~release_meta);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rem_d        = rem_q;
    size_w_d     = size_w_q;
    lat_w_d      = lat_w_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    tx_last_d    = tx_last_q;
    busy_d       = busy_q;
    release_meta = 1'b0;
    fifo_pop     = 1'b0;
    body_done    = 1'b0;
    case (state_q)
      S_IDLE: if (meta_full_q) begin
        state_d      = S_SYNC;
        release_meta = 1'b1;
        size_w_d     = meta_size_q;
        lat_w_d      = meta_lat_q;
        idx_d        = 2'd0;
        tx_data_d    = SYNC_BYTE;
        tx_valid_d   = 1'b1;
        tx_last_d    = 1'b0;
        busy_d       = 1'b1;
      end
      S_SYNC: if (xfer) begin
        state_d   = S_SIZE;
        idx_d     = 2'd0;
        tx_data_d = size_w_q[7:0];
      end
      S_SIZE: if (xfer) begin
        if (idx_q == 2'd3) begin
          state_d   = S_LAT;
          idx_d     = 2'd0;
          tx_data_d = lat_w_q[7:0];
        end else begin
          idx_d     = idx_q + 2'd1;
          tx_data_d = byte_of(size_w_q, idx_q + 2'd1);
        end
      end
      S_LAT: if (xfer) begin
        if (idx_q != 2'd3) begin
          idx_d     = idx_q + 2'd1;
          tx_data_d = byte_of(lat_w_q, idx_q + 2'd1);
          tx_last_d = !HAS_CRC && (idx_q == 2'd2) && (size_w_q == '0);
        end else if (size_w_q == '0) begin
          body_done = 1'b1;
        end else begin
          state_d = S_PAYLOAD;
          idx_d   = 2'd0;
          rem_d   = size_w_q;
          if (fifo_empty) begin
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
          end else begin
            tx_data_d = head_word[7:0];
            tx_last_d = !HAS_CRC && (size_w_q == 32'd1);
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          rem_d = rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            fifo_pop  = 1'b1;
            body_done = 1'b1;
          end else if (idx_q == 2'd3) begin
            // Look one word ahead so word boundaries cost no bubble.
            fifo_pop = 1'b1;
            idx_d    = 2'd0;
            if (fifo_multi) begin
              tx_data_d = next_word[7:0];
              tx_last_d = !HAS_CRC && (rem_q == 32'd2);
            end else begin
              tx_valid_d = 1'b0;
              tx_last_d  = 1'b0;
            end
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = byte_of(head_word, idx_q + 2'd1);
            tx_last_d = !HAS_CRC && (rem_q == 32'd2);
          end
        end else if (!tx_valid_q && !fifo_empty) begin
          tx_valid_d = 1'b1;
          tx_data_d  = byte_of(head_word, idx_q);
          tx_last_d  = !HAS_CRC && (rem_q == 32'd1);
        end
      end
`ifdef TASK_ANSWER_PACKETIZER_CRC_EN
      S_CRC: if (xfer) begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        busy_d     = 1'b0;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (body_done) begin
`ifdef TASK_ANSWER_PACKETIZER_CRC_EN
      state_d   = S_CRC;
      tx_data_d = crc8_byte(crc_q, tx_data_q);
      tx_last_d = 1'b1;
`else
      state_d    = S_IDLE;
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
      busy_d     = 1'b0;
`endif
    end
  end

`ifdef TASK_ANSWER_PACKETIZER_CRC_EN
  always_comb begin
    crc_d = crc_q;
    if (state_q == S_IDLE) crc_d = '0;
    else if (xfer && state_q != S_CRC) crc_d = crc8_byte(crc_q, tx_data_q);
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      meta_full_q <= 1'b0;
      meta_size_q <= '0;
      meta_lat_q  <= '0;
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      size_w_q    <= '0;
      lat_w_q     <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef TASK_ANSWER_PACKETIZER_CRC_EN
      crc_q       <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      meta_full_q <= meta_full_d;
      meta_size_q <= meta_size_d;
      meta_lat_q  <= meta_lat_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      size_w_q    <= size_w_d;
      lat_w_q     <= lat_w_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
`ifdef TASK_ANSWER_PACKETIZER_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_tx_last  = tx_last_q;
  assign o_busy     = busy_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_task_answer_packetizer.sv
// Scoreboard bench for task_answer_packetizer: a word-stream model predicts every packet byte.
module tb_task_answer_packetizer;
`ifdef TASK_ANSWER_PACKETIZER_CRC_EN
  localparam int HAS_CRC = 1;
`else
  localparam int HAS_CRC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_answer_valid = 1'b0, i_answer_last = 1'b0, i_tx_ready = 1'b0;
  logic [31:0] i_answer_data = '0, i_answer_size = '0, i_answer_lat = '0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid, o_tx_last, o_busy, o_overflow;

  logic        a4_valid = 1'b0, a4_last = 1'b0, tx4_ready = 1'b1;
  logic [31:0] a4_data = '0, a4_size = '0, a4_lat = '0;
  logic [7:0]  tx4_data;
  logic        tx4_valid, tx4_last, busy4, ovf4;

  always #5 clk = ~clk;

  task_answer_packetizer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_answer_valid(i_answer_valid), .i_answer_data(i_answer_data),
    .i_answer_last(i_answer_last), .i_answer_size_in_bytes(i_answer_size),
    .i_answer_latency(i_answer_lat),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_tx_last(o_tx_last), .o_busy(o_busy), .o_overflow(o_overflow));

  task_answer_packetizer #(.FIFO_DEPTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_answer_valid(a4_valid), .i_answer_data(a4_data),
    .i_answer_last(a4_last), .i_answer_size_in_bytes(a4_size),
    .i_answer_latency(a4_lat),
    .o_tx_data(tx4_data), .o_tx_valid(tx4_valid), .i_tx_ready(tx4_ready),
    .o_tx_last(tx4_last), .o_busy(busy4), .o_overflow(ovf4));

  int n_checks = 0, n_fail = 0;
  logic [8:0]  exp_q[$];
  logic [31:0] model_words[$];
  int starts = 0, start_base = 0, pkt_issued = 0, xfers = 0, ready_mode = 0;
  logic [31:0] stim_words[8];
  int          stim_n, gap_max;
  logic [31:0] stim_size, stim_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c = crc;
    for (int i = 7; i >= 0; i--) begin
      logic fb = c[7] ^ b[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Packet = sync, size LE, latency LE, first `size` bytes of the word stream, optional CRC.
  task automatic build_expect(input logic [31:0] size, input logic [31:0] lat);
    logic [7:0]  bytes[$];
    logic [31:0] w = '0;
    logic [7:0]  crc = 8'h00;
    bytes.push_back(8'hA5);
    for (int i = 0; i < 4; i++) bytes.push_back(8'(size >> (8 * i)));
    for (int i = 0; i < 4; i++) bytes.push_back(8'(lat >> (8 * i)));
    for (int j = 0; j < int'(size); j++) begin
      if (j % 4 == 0) w = model_words.pop_front();
      bytes.push_back(8'(w >> (8 * (j % 4))));
    end
    if (HAS_CRC != 0) begin
      foreach (bytes[i]) crc = crc_step(crc, bytes[i]);
      bytes.push_back(crc);
    end
    foreach (bytes[i]) exp_q.push_back({i == bytes.size() - 1, bytes[i]});
  endtask

  task automatic send_packet();
    int cyc;
    for (int i = 0; i < stim_n; i++) begin
      @(posedge clk); #1;
      i_answer_valid = 1'b0; i_answer_last = 1'b0;
      if (i > 0 && gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      if (i == stim_n - 1) begin
        cyc = 0;
        while ((starts - start_base) < pkt_issued && cyc < 5000) begin @(posedge clk); #1; cyc++; end
        if (cyc >= 5000) chk("meta_slot_wait", 32'(cyc), 32'd0);
      end
      i_answer_valid = 1'b1;
      i_answer_data  = stim_words[i];
      i_answer_last  = (i == stim_n - 1);
      i_answer_size  = i_answer_last ? stim_size : $urandom;
      i_answer_lat   = i_answer_last ? stim_lat : $urandom;
      model_words.push_back(stim_words[i]);
      if (i_answer_last) begin build_expect(stim_size, stim_lat); pkt_issued++; end
    end
    @(posedge clk); #1;
    i_answer_valid = 1'b0; i_answer_last = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || o_busy) && cyc < 4000) begin @(negedge clk); cyc++; end
    if (cyc >= 4000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_req029();
    stim_words[0] = 32'h44332211; stim_words[1] = 32'h88776655;
    stim_n = 2; stim_size = 32'd8; stim_lat = 32'h10; gap_max = 0;
  endtask

  // Ready generator: 0 = held high, 1 = toggling, 2 = random.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: i_tx_ready = 1'b1;
      1: i_tx_ready = ~i_tx_ready;
      default: i_tx_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Monitor: pops one expected byte per transfer and checks hold-stability during stalls.
  initial begin
    logic       prev_stall = 1'b0, prev_busy = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin prev_stall = 1'b0; prev_busy = 1'b0; continue; end
      if (prev_stall) chk("stall_hold", {22'd0, o_tx_valid, o_tx_last, o_tx_data},
                          {22'd0, 1'b1, prev_last, prev_data});
      if (o_busy && !prev_busy) starts++;
      prev_busy = o_busy;
      if (o_tx_valid && !o_busy) chk("busy_with_valid", 32'(o_busy), 32'd1);
      if (o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("tx_byte{last,data}", {23'd0, o_tx_last, o_tx_data}, {23'd0, e});
        end
        xfers++;
      end
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data  = o_tx_data;
      prev_last  = o_tx_last;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, base, cyc;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_tx_last", 32'(o_tx_last), 32'd0);
    chk("rst_tx_data", 32'(o_tx_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_overflow", {30'd0, o_overflow, ovf4}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic packet, latency and throughput with ready held high.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    load_req029();
    send_packet();
    n = 0;
    do begin @(negedge clk); n++; end while (!o_tx_valid && n < 20);
    chk("first_valid_latency", 32'(n), 32'd2);
    chk("first_byte_sync", 32'(o_tx_data), 32'hA5);
    k = 1;
    while (!(o_tx_valid && i_tx_ready && o_tx_last) && k < 100) begin @(negedge clk); k++; end
    chk("packet_cycles", 32'(k), 32'(17 + HAS_CRC));
    wait_drain();

    // Same packet with ready toggling.
    ready_mode = 1;
    load_req029();
    send_packet();
    wait_drain();

    // Partial final word: upper byte discarded, then a fresh word must follow cleanly.
    ready_mode = 0;
    stim_words[0] = 32'hDDCCBBAA; stim_n = 1; stim_size = 3; stim_lat = 32'h0000_0123; gap_max = 0;
    send_packet();
    stim_words[0] = 32'h04030201; stim_n = 1; stim_size = 4; stim_lat = 32'h7;
    send_packet();
    wait_drain();

    // Zero-size packet; its carrier word stays in the stream for the next packet.
    stim_words[0] = 32'hCAFEF00D; stim_n = 1; stim_size = 0; stim_lat = 5;
    send_packet();
    wait_drain();
    stim_words[0] = 32'h11111111; stim_n = 1; stim_size = 6; stim_lat = 9;
    send_packet();
    wait_drain();

    // Randomized packets, back-to-back metadata, random ready and word gaps.
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      stim_size = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 24));
      stim_lat  = $urandom;
      stim_n    = (stim_size == 0) ? 1 : int'((stim_size + 3) / 4);
      for (int i = 0; i < stim_n; i++) stim_words[i] = $urandom;
      gap_max   = $urandom_range(0, 3);
      send_packet();
    end
    wait_drain();
    chk("no_overflow_main", 32'(o_overflow), 32'd0);

    // Reset mid-payload, then a clean packet after release.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    base = xfers;
    load_req029();
    send_packet();
    cyc = 0;
    while (xfers < base + 12 && cyc < 200) begin @(posedge clk); cyc++; end
    chk("reach_third_payload", 32'(xfers - base), 32'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {21'd0, o_tx_valid, o_tx_last, o_busy, o_tx_data}, 32'd0);
    exp_q.delete();
    model_words.delete();
    pkt_issued = 0;
    start_base = starts;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    stim_words[0] = $urandom; stim_words[1] = $urandom; stim_n = 2; stim_size = 7;
    stim_lat = $urandom; gap_max = 0;
    send_packet();
    wait_drain();

    // Small FIFO: fifth undrained word overflows, flag is sticky.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a4_valid = 1'b1; a4_data = 32'(i + 1);
      if (i == 4) begin
        @(negedge clk);
        chk("ovf4_after_4_words", 32'(ovf4), 32'd0);
      end
    end
    @(posedge clk); #1 a4_valid = 1'b0;
    @(negedge clk);
    chk("ovf4_after_5th_word", 32'(ovf4), 32'd1);
    repeat (5) @(negedge clk);
    chk("ovf4_sticky", 32'(ovf4), 32'd1);
    rst_n = 1'b0;
    #1 chk("ovf4_reset_clear", 32'(ovf4), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Three lasts in consecutive cycles: the third meets a full metadata slot.
    a4_size = 0; a4_lat = 32'h3;
    @(posedge clk); #1 a4_valid = 1'b1; a4_last = 1'b1; a4_data = 32'hA;
    @(posedge clk); #1 a4_data = 32'hB;
    @(posedge clk); #1 a4_data = 32'hC;
    @(negedge clk);
    chk("ovf4_meta_two_lasts", 32'(ovf4), 32'd0);
    @(posedge clk); #1 a4_valid = 1'b0; a4_last = 1'b0;
    @(negedge clk);
    chk("ovf4_meta_third_last", 32'(ovf4), 32'd1);
    repeat (40) @(negedge clk);
    chk("ovf4_meta_sticky", 32'(ovf4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/task_answer_packetizer.md
TASK_ANSWER_PACKETIZER -- requirements
Module: task_answer_packetizer

Interface
REQ-001 Parameter FIFO_DEPTH, default 256: payload word buffer depth in 32-bit words; power of two, at least 4.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: first byte of every packet.
REQ-003 i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_answer_valid  input  1  answer word valid, no backpressure.
REQ-006 i_answer_data  input  32  answer word; byte 0 is bits [7:0].
REQ-007 i_answer_last  input  1  last word of the answer, qualified by valid.
REQ-008 i_answer_size_in_bytes  input  32  payload byte count, sampled with the last word.
REQ-009 i_answer_latency  input  32  task latency, sampled with the last word.
REQ-010 o_tx_data  output  8  byte to UART transmitter.
REQ-011 o_tx_valid  output  1  o_tx_data valid.
REQ-012 i_tx_ready  input  1  transmitter accepts the byte; transfer happens when valid and ready are both high.
REQ-013 o_tx_last  output  1  final byte of the packet, qualified by o_tx_valid.
REQ-014 o_busy  output  1  high from header start until the last-byte transfer.
REQ-015 o_overflow  output  1  sticky error flag, cleared only by reset.

Function
REQ-016 Word buffer: each valid word is written to the FIFO. A write while the FIFO is full drops the word and sets o_overflow.
REQ-017 Metadata register, single entry:
- Loads size and latency and sets meta_full on valid&last.
- If valid&last arrives while meta_full is set and no release occurs in the same cycle, the new metadata is dropped and o_overflow is set.
- A release and a load in the same cycle both take effect, and meta stays full.
REQ-018 FSM states are IDLE, SYNC, SIZE, LAT, PAYLOAD, and CRC (CRC only when the macro is defined).
- IDLE to SYNC in the cycle after meta_full is seen; metadata is copied to working registers and meta_full is released in that cycle.
REQ-019 SYNC emits SYNC_BYTE. SIZE emits 4 size bytes, little-endian. LAT emits 4 latency bytes, little-endian. Each state advances only on a transfer.
REQ-020 PAYLOAD byte order and count:
- Emits words from the FIFO byte 0 first.
- Emits exactly size bytes, counted with a 32-bit down-counter.
- A word is popped after its 4th byte, or after the final byte.
- Unused upper bytes of the final word are discarded.
REQ-021 If size is 0, PAYLOAD is skipped and the packet ends after LAT (or after CRC when enabled).
REQ-022 If the FIFO is empty in PAYLOAD, o_tx_valid is held low (stall) until a word arrives; no byte is skipped.
REQ-023 While o_tx_valid is high and i_tx_ready is low, o_tx_data and o_tx_last stay stable.
REQ-024 Latency: first o_tx_valid is asserted 2 cycles after the valid&last input cycle, when idle. Throughput is 1 byte per cycle when i_tx_ready is held high.
REQ-025 After the last-byte transfer the FSM returns to IDLE. A pending meta_full starts the next packet with no extra idle cycle beyond REQ-018.

Reset
REQ-026 While i_rst_n is low:
- FSM is in IDLE; FIFO, metadata, and counters are cleared.
- o_tx_valid=0, o_tx_last=0, o_tx_data=8'h00, o_busy=0, o_overflow=0.
REQ-027 Reset asserted mid-packet aborts the packet immediately. There is no resume after release; the first packet after release starts with SYNC_BYTE.

Configuration
REQ-028 Macro TASK_ANSWER_PACKETIZER_CRC_EN controls the packet trailer.
- Defined: a CRC state appends one CRC-8 byte (poly 0x07, init 0x00, no reflection, no final XOR) over all bytes from SYNC through the end of payload; o_tx_last is asserted on the CRC byte.
- Undefined: no CRC logic is built, and o_tx_last is on the final payload byte, or on the final latency byte when size is 0.

Verification
REQ-029 Words 0x44332211 and 0x88776655 (last on the second), size=8, latency=0x10, ready held high -> bytes A5 08 00 00 00 10 00 00 00 11 22 33 44 55 66 77 88; last on 0x88 (no CRC).
REQ-030 One word 0xDDCCBBAA with last, size=3 -> payload AA BB CC only; 0xDD is discarded; the FIFO is empty afterwards.
REQ-031 size=0, latency=5 -> 9 bytes; o_tx_last on the 4th latency byte (0x00). With the macro defined: a 10th byte equal to CRC-8 of the first 9 bytes, with last on it.
REQ-032 i_tx_ready toggling every other cycle during the REQ-029 packet -> identical byte sequence; o_tx_data is stable during every stall cycle.
REQ-033 FIFO_DEPTH=4, 5 words pushed with no drain -> 5th word is dropped and o_overflow goes high and stays high. A second last arriving while meta_full is set also sets o_overflow.
REQ-034 i_rst_n pulled low after the 3rd payload byte -> outputs take reset values asynchronously. After release, a new packet begins with A5.
